// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sqrt_arbiter : round-robin sharing of one square-root core among N_REQ
//                valid/ready requesters; includes the iterative core.
// Revision     : 1.0  initial release
// ---------------------------------------------------------------------------

module cordic_sqrt #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [IN_WIDTH-1:0]  x_i,
  output logic [OUT_WIDTH-1:0] y_o,
  output logic                 is_neg_o,
  output logic                 done_o
);

  // Remainder stays below 2*root+1, so OUT_WIDTH+3 bits hold the shifted value.
  localparam int RW    = OUT_WIDTH + 3;
  localparam int CNT_W = $clog2(OUT_WIDTH + 1);

  logic [IN_WIDTH-1:0]  x_q,    x_d;
  logic [RW-1:0]        rem_q,  rem_d;
  logic [OUT_WIDTH-1:0] root_q, root_d;
  logic [CNT_W-1:0]     cnt_q,  cnt_d;
  logic                 run_q,  run_d;
  logic                 neg_q,  neg_d;
  logic                 done_q, done_d;

  logic [RW-1:0] rem_shift;
  logic [RW-1:0] trial;
  logic [RW-1:0] diff;
  logic          ge;

  always_comb begin
    rem_shift = (rem_q << 2) | {{(RW-2){1'b0}}, x_q[IN_WIDTH-1 -: 2]};
    trial     = {1'b0, root_q, 2'b01};
    diff      = rem_shift - trial;
    ge        = (rem_shift >= trial);

    x_d    = x_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    neg_d  = neg_q;
    done_d = 1'b0;

    if (start_i) begin
      neg_d  = x_i[IN_WIDTH-1];
      x_d    = x_i[IN_WIDTH-1] ? '0 : x_i;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = CNT_W'(OUT_WIDTH - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      x_d    = x_q << 2;
      rem_d  = ge ? diff : rem_shift;
      root_d = {root_q[OUT_WIDTH-2:0], ge};
      if (cnt_q == '0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      neg_q  <= neg_d;
      done_q <= done_d;
    end
  end

  assign y_o      = root_q;
  assign is_neg_o = neg_q;
  assign done_o   = done_q;

endmodule

module sqrt_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = IN_WIDTH / 2,
  parameter int ID_W      = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*IN_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [OUT_WIDTH-1:0]      rsp_root,
  output logic                      rsp_neg,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t               state_q,      state_d;
  logic [ID_W-1:0]      grant_q,      grant_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [IN_WIDTH-1:0]  operand_q,    operand_d;
  logic [OUT_WIDTH-1:0] root_q,       root_d;
  logic                 neg_q,        neg_d;

  logic [ID_W-1:0]      winner;
  logic                 any_req;
  logic [ID_W-1:0]      idx;
  int                   idx_i;

  logic                 core_start;
  logic [OUT_WIDTH-1:0] core_root;
  logic                 core_neg;
  logic                 core_done;

  // Search starts just after the last served requester, wrapping modulo N_REQ.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    idx_i   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_i = int'(last_grant_q) + k;
      if (idx_i >= N_REQ) begin
        idx_i = idx_i - N_REQ;
      end
      idx = ID_W'(idx_i);
      if (!any_req && req_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    operand_d    = operand_q;
    root_d       = root_q;
    neg_d        = neg_q;
    req_ready    = '0;
    rsp_valid    = '0;
    core_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req_ready = N_REQ'(1) << winner;
          operand_d = req_data[int'(winner) * IN_WIDTH +: IN_WIDTH];
          grant_d   = winner;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          root_d  = core_root;
          neg_d   = core_neg;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = N_REQ'(1) << grant_q;
        if (rsp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= LAST_ID;
      last_grant_q <= LAST_ID;
      operand_q    <= '0;
      root_q       <= '0;
      neg_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      operand_q    <= operand_d;
      root_q       <= root_d;
      neg_q        <= neg_d;
    end
  end

  cordic_sqrt #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (core_start),
    .x_i      (operand_q),
    .y_o      (core_root),
    .is_neg_o (core_neg),
    .done_o   (core_done)
  );

  assign rsp_root = root_q;
  assign rsp_neg  = neg_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sqrt_arbiter : directed self-checking bench for sqrt_arbiter.
// Revision        : 1.0  initial release
// ---------------------------------------------------------------------------

module tb_sqrt_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_data;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [15:0]  rsp_root;
  logic         rsp_neg;
  logic         busy;
  logic [1:0]   grant_id;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sqrt_arbiter #(
    .N_REQ    (4),
    .IN_WIDTH (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_root  (rsp_root),
    .rsp_neg   (rsp_neg),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set_data(input int id, input logic [31:0] v);
    req_data[id*32 +: 32] = v;
  endtask

  // Invariant monitor, sampled just before each rising edge.
  initial begin
    logic        prev_acc;
    logic        prev_pend;
    logic [15:0] prev_root;
    logic        prev_neg;
    logic [3:0]  prev_rv;
    prev_acc  = 1'b0;
    prev_pend = 1'b0;
    prev_root = '0;
    prev_neg  = 1'b0;
    prev_rv   = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1) begin
        checks++;
        if ($countones(req_ready) > 1) begin
          errors++;
          $display("FAIL req_ready_onehot: got %b, need at most one bit", req_ready);
        end
        checks++;
        if ($countones(rsp_valid) > 1) begin
          errors++;
          $display("FAIL rsp_valid_onehot: got %b, need at most one bit", rsp_valid);
        end
        checks++;
        if (dut.core_start !== prev_acc) begin
          errors++;
          $display("FAIL start_timing: start=%b, expected %b (cycle %0d)", dut.core_start, prev_acc, cyc);
        end
        if (prev_pend && rsp_valid !== 4'b0) begin
          checks++;
          if (rsp_root !== prev_root || rsp_neg !== prev_neg || rsp_valid !== prev_rv) begin
            errors++;
            $display("FAIL rsp_stable: got root=%0d neg=%b valid=%b, held root=%0d neg=%b valid=%b",
                     rsp_root, rsp_neg, rsp_valid, prev_root, prev_neg, prev_rv);
          end
        end
        prev_acc  = |(req_valid & req_ready);
        prev_pend = (|rsp_valid) && !(|(rsp_valid & rsp_ready));
        prev_root = rsp_root;
        prev_neg  = rsp_neg;
        prev_rv   = rsp_valid;
      end else begin
        prev_acc  = 1'b0;
        prev_pend = 1'b0;
      end
    end
  end

  task automatic test_reset;
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, expected 0000/0000", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_root !== 16'd0 || rsp_neg !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: root=%0d neg=%b, expected 0/0", rsp_root, rsp_neg);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL reset_state: busy=%b grant_id=%0d, expected 0/3", busy, grant_id);
    end
  endtask

  task automatic test_round_robin;
    int exp_id [5];
    int exp_rt [5];
    int last_acc;
    exp_id = '{0, 1, 2, 3, 0};
    exp_rt = '{2, 3, 4, 5, 2};
    last_acc = 0;
    set_data(0, 32'd4);
    set_data(1, 32'd9);
    set_data(2, 32'd16);
    set_data(3, 32'd25);
    req_valid = 4'hF;
    #1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 40 && req_ready === 4'b0; k++) tick;
      checks++;
      if (req_ready !== (4'b1 << exp_id[j])) begin
        errors++;
        $display("FAIL rr_grant%0d: req_ready=%b, expected %b", j, req_ready, 4'b1 << exp_id[j]);
      end
      if (j > 0) begin
        checks++;
        if (cyc - last_acc != 20) begin
          errors++;
          $display("FAIL rr_spacing%0d: %0d cycles, expected 20", j, cyc - last_acc);
        end
      end
      last_acc = cyc;
      tick;
      if (j == 4) req_valid = 4'b0;
      for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
      checks++;
      if (rsp_valid !== (4'b1 << exp_id[j]) || rsp_root !== 16'(exp_rt[j]) || rsp_neg !== 1'b0) begin
        errors++;
        $display("FAIL rr_result%0d: valid=%b root=%0d neg=%b, expected %b/%0d/0",
                 j, rsp_valid, rsp_root, rsp_neg, 4'b1 << exp_id[j], exp_rt[j]);
      end
      tick;
    end
  endtask

  task automatic test_single;
    logic [31:0] ops   [4];
    logic [15:0] roots [4];
    int          t0;
    ops   = '{32'd144, 32'd1000000, 32'h7FFF_FFFF, 32'd0};
    roots = '{16'd12, 16'd1000, 16'd46340, 16'd0};
    for (int i = 0; i < 4; i++) begin
      tick;
      set_data(0, ops[i]);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL single_accept%0d: req_ready=%b, expected 0001", i, req_ready);
      end
      t0 = cyc;
      tick;
      req_valid = 4'b0;
      for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
      checks++;
      if (cyc - t0 != 19) begin
        errors++;
        $display("FAIL single_latency%0d: rsp_valid after %0d cycles, expected 19", i, cyc - t0);
      end
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_root !== roots[i] || rsp_neg !== 1'b0 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL single_result%0d: valid=%b root=%0d neg=%b id=%0d, expected 0001/%0d/0/0",
                 i, rsp_valid, rsp_root, rsp_neg, grant_id, roots[i]);
      end
      tick;
    end
  endtask

  task automatic test_negative;
    tick;
    set_data(2, -32'sd5);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL neg_accept: req_ready=%b, expected 0100", req_ready);
    end
    tick;
    req_valid = 4'b0;
    for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_root !== 16'd0 || rsp_neg !== 1'b1 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL neg_result: valid=%b root=%0d neg=%b id=%0d, expected 0100/0/1/2",
               rsp_valid, rsp_root, rsp_neg, grant_id);
    end
    tick;
  endtask

  task automatic test_back_pressure;
    tick;
    rsp_ready = 4'b1101;
    set_data(1, 32'd81);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_accept: req_ready=%b, expected 0010", req_ready);
    end
    tick;
    req_valid = 4'b0;
    for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_root !== 16'd9) begin
      errors++;
      $display("FAIL bp_result: valid=%b root=%0d, expected 0010/9", rsp_valid, rsp_root);
    end
    set_data(0, 32'd4);
    req_valid = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick;
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_root !== 16'd9 || rsp_neg !== 1'b0 ||
          busy !== 1'b1 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b root=%0d neg=%b busy=%b req_ready=%b, expected 0010/9/0/1/0000",
                 k, rsp_valid, rsp_root, rsp_neg, busy, req_ready);
      end
    end
    rsp_ready = 4'b1111;
    tick;
    checks++;
    if (rsp_valid !== 4'b0 || req_ready !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b req_ready=%b busy=%b, expected 0000/0001/0",
               rsp_valid, req_ready, busy);
    end
    tick;
    req_valid = 4'b0;
    for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_root !== 16'd2) begin
      errors++;
      $display("FAIL bp_next: valid=%b root=%0d, expected 0001/2", rsp_valid, rsp_root);
    end
    tick;
  endtask

  task automatic test_priority;
    logic bad;
    tick;
    set_data(3, 32'd36);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL prio_accept3: req_ready=%b, expected 1000", req_ready);
    end
    tick;
    req_valid = 4'b0;
    for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
    checks++;
    if (rsp_valid !== 4'b1000 || rsp_root !== 16'd6) begin
      errors++;
      $display("FAIL prio_result3: valid=%b root=%0d, expected 1000/6", rsp_valid, rsp_root);
    end
    tick;
    set_data(1, 32'd100);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL prio_accept1: req_ready=%b, expected 0010", req_ready);
    end
    tick;
    req_valid = 4'b0;
    for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_root !== 16'd10) begin
      errors++;
      $display("FAIL prio_result1: valid=%b root=%0d, expected 0010/10", rsp_valid, rsp_root);
    end
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (req_ready !== 4'b0 || grant_id !== 2'd1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL prio_dropped3: req_ready=%b grant_id=%0d busy=%b, expected 0000/1/0",
               req_ready, grant_id, busy);
    end
  endtask

  task automatic test_reset_abort;
    logic stale;
    int   t0;
    tick;
    set_data(0, 32'd64);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL abort_accept: req_ready=%b, expected 0001", req_ready);
    end
    tick;
    req_valid = 4'b0;
    repeat (5) tick;
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL abort_busy: busy=%b id=%0d, expected 1/0", busy, grant_id);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd3 || rsp_valid !== 4'b0 || req_ready !== 4'b0 ||
        rsp_root !== 16'd0 || rsp_neg !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b id=%0d valid=%b ready=%b root=%0d neg=%b, expected 0/3/0000/0000/0/0",
               busy, grant_id, rsp_valid, req_ready, rsp_root, rsp_neg);
    end
    repeat (3) tick;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL abort_stale: valid=%b busy=%b, expected 0000/0", rsp_valid, busy);
    end
    set_data(0, 32'd49);
    set_data(1, 32'd4);
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL abort_first: req_ready=%b, expected 0001", req_ready);
    end
    t0 = cyc;
    tick;
    req_valid = 4'b0;
    for (int k = 0; k < 40 && rsp_valid === 4'b0; k++) tick;
    checks++;
    if (cyc - t0 != 19 || rsp_valid !== 4'b0001 || rsp_root !== 16'd7 || rsp_neg !== 1'b0) begin
      errors++;
      $display("FAIL abort_result: latency=%0d valid=%b root=%0d neg=%b, expected 19/0001/7/0",
               cyc - t0, rsp_valid, rsp_root, rsp_neg);
    end
    tick;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0;
    req_data  = '0;
    rsp_ready = 4'b1111;
    repeat (3) tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_round_robin;
    test_single;
    test_negative;
    test_back_pressure;
    test_priority;
    test_reset_abort;
    repeat (3) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
